// File: rtl/part_2_xfer_sched.sv
// Fringe-channel transfer scheduler: turns mission-clock rising edges into pending
// transfers, grants them round-robin onto one put/get port, freezes stalled channels.
module part_2_xfer_sched #(
  parameter int N_CH     = 4,
  parameter int DW       = 9,
  parameter int CW       = $clog2(N_CH),
  parameter int WD_LIMIT = 10000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_CH-1:0]      clk_h_i,
  input  logic                 put_en_i,
  input  logic                 get_en_i,
  input  logic [N_CH*DW-1:0]   tx_data_i,
  output logic                 put_req_o,
  output logic [CW-1:0]        put_ch_o,
  output logic [DW-1:0]        put_data_o,
  input  logic                 put_ack_i,
  output logic                 get_req_o,
  output logic [CW-1:0]        get_ch_o,
  input  logic                 get_ack_i,
  input  logic                 get_valid_i,
  input  logic [DW-1:0]        get_data_i,
  output logic [N_CH-1:0]      rx_valid_o,
  output logic [N_CH*DW-1:0]   rx_data_o,
  output logic [N_CH-1:0]      freeze_clk_o,
  output logic [N_CH-1:0]      ovr_o,
  output logic                 wd_err_o,
  output logic                 busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PUT  = 2'd1;
  localparam logic [1:0] S_GET  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]         r_state;
  logic [N_CH-1:0]    r_clk_h_d;
  logic [N_CH-1:0]    r_pending;
  logic [CW-1:0]      r_last_gnt;
  logic [CW-1:0]      r_gnt;
  logic [DW-1:0]      r_put_data;
  logic [31:0]        r_wd;
  logic [N_CH-1:0]    r_rx_valid;
  logic [N_CH*DW-1:0] r_rx_data;
  logic [N_CH-1:0]    r_freeze;
  logic [N_CH-1:0]    r_ovr;
  logic               r_wd_err;

  logic [N_CH-1:0]    w_rise;
  logic [N_CH-1:0]    w_clr;
  logic [CW-1:0]      w_cand [N_CH];
  logic [CW-1:0]      w_gnt_ch;
  logic               w_any;
  logic               w_done;
  logic               w_drop;

  assign w_rise = clk_h_i & ~r_clk_h_d;

  // Candidate i is the channel i+1 places after the last grant, so the first hit wins.
  always_comb begin
    w_any    = 1'b0;
    w_gnt_ch = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_cand[i] = CW'((32'(r_last_gnt) + i + 1) % N_CH);
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!w_any && r_pending[w_cand[i]]) begin
        w_any    = 1'b1;
        w_gnt_ch = w_cand[i];
      end
    end
  end

  assign w_done = ((r_state == S_PUT) && put_ack_i && !get_en_i) ||
                  ((r_state == S_GET) && get_ack_i && get_valid_i);
  assign w_drop = (r_state == S_IDLE) && w_any && !put_en_i && !get_en_i;

  always_comb begin
    w_clr = '0;
    if (w_done) w_clr[r_gnt]    = 1'b1;
    if (w_drop) w_clr[w_gnt_ch] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_clk_h_d  <= '0;
      r_pending  <= '0;
      r_last_gnt <= CW'(N_CH - 1);
      r_gnt      <= '0;
      r_put_data <= '0;
      r_wd       <= '0;
      r_rx_valid <= '0;
      r_rx_data  <= '0;
      r_freeze   <= '0;
      r_ovr      <= '0;
      r_wd_err   <= 1'b0;
    end else begin
      r_clk_h_d  <= clk_h_i;
      // A new edge on the completing channel re-arms it instead of counting as overrun.
      r_pending  <= (r_pending & ~w_clr) | w_rise;
      r_ovr      <= r_ovr | (w_rise & r_pending & ~w_clr);
      r_rx_valid <= '0;
      if (w_done) begin
        r_last_gnt <= r_gnt;
        r_wd       <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_any && (put_en_i || get_en_i)) begin
            r_gnt      <= w_gnt_ch;
            r_put_data <= tx_data_i[int'(w_gnt_ch)*DW +: DW];
            if (put_en_i) begin
              r_state <= S_PUT;
            end else begin
              r_state <= S_GET;
              r_wd    <= '0;
            end
          end
        end
        S_PUT: begin
          if (put_ack_i) begin
            if (get_en_i) begin
              r_state <= S_GET;
              r_wd    <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_GET: begin
          if (get_ack_i && get_valid_i) begin
            r_rx_data[int'(r_gnt)*DW +: DW] <= get_data_i;
            r_rx_valid[r_gnt] <= 1'b1;
            r_freeze[r_gnt]   <= 1'b0;
            r_state           <= S_IDLE;
          end else begin
            if (get_ack_i) r_freeze[r_gnt] <= 1'b1;
            if (r_wd >= 32'(WD_LIMIT - 1)) begin
              r_state  <= S_ERR;
              r_freeze <= '1;
              r_wd_err <= 1'b1;
            end else begin
              r_wd <= r_wd + 32'd1;
            end
          end
        end
        default: begin
          r_freeze <= '1;
          r_wd_err <= 1'b1;
        end
      endcase
    end
  end

  assign put_req_o    = (r_state == S_PUT);
  assign get_req_o    = (r_state == S_GET);
  assign put_ch_o     = r_gnt;
  assign get_ch_o     = r_gnt;
  assign put_data_o   = r_put_data;
  assign rx_valid_o   = r_rx_valid;
  assign rx_data_o    = r_rx_data;
  assign freeze_clk_o = r_freeze;
  assign ovr_o        = r_ovr;
  assign wd_err_o     = r_wd_err;
  assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_part_2_xfer_sched.sv
// Directed bench for part_2_xfer_sched: latency, round-robin order, freeze,
// watchdog, overrun, enables and reset abort.
module tb_part_2_xfer_sched;
  localparam int N_CH = 4;
  localparam int DW   = 9;
  localparam int CW   = 2;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [N_CH-1:0]     clk_h_i;
  logic                put_en_i, get_en_i;
  logic [N_CH*DW-1:0]  tx_data_i;
  logic                put_req_o, get_req_o;
  logic [CW-1:0]       put_ch_o, get_ch_o;
  logic [DW-1:0]       put_data_o;
  logic                put_ack_i, get_ack_i, get_valid_i;
  logic [DW-1:0]       get_data_i;
  logic [N_CH-1:0]     rx_valid_o, freeze_clk_o, ovr_o;
  logic [N_CH*DW-1:0]  rx_data_o;
  logic                wd_err_o, busy_o;

  int errors = 0;
  int checks = 0;

  part_2_xfer_sched #(.N_CH(N_CH), .DW(DW), .WD_LIMIT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_h_i(clk_h_i),
    .put_en_i(put_en_i), .get_en_i(get_en_i), .tx_data_i(tx_data_i),
    .put_req_o(put_req_o), .put_ch_o(put_ch_o), .put_data_o(put_data_o),
    .put_ack_i(put_ack_i), .get_req_o(get_req_o), .get_ch_o(get_ch_o),
    .get_ack_i(get_ack_i), .get_valid_i(get_valid_i), .get_data_i(get_data_i),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .freeze_clk_o(freeze_clk_o),
    .ovr_o(ovr_o), .wd_err_o(wd_err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    clk_h_i = '0; put_en_i = 0; get_en_i = 0; put_ack_i = 0;
    get_ack_i = 0; get_valid_i = 0; get_data_i = '0;
  endtask

  task automatic apply_reset();
    rst_i = 1; tick(); tick(); rst_i = 0;
  endtask

  task automatic wait_put(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (put_req_o) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic wait_get(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (get_req_o) begin ok = 1; break; end
      tick();
    end
  endtask

  // Runs one full transfer with immediate acks; rise_mask is driven on the put-ack cycle.
  task automatic serve(input logic [3:0] rise_mask, input logic [8:0] data,
                       output int ch, output bit ok);
    bit ok1, ok2;
    wait_put(ok1);
    ch = int'(put_ch_o);
    clk_h_i = rise_mask; put_ack_i = 1; tick(); put_ack_i = 0; clk_h_i = '0;
    wait_get(ok2);
    get_ack_i = 1; get_valid_i = 1; get_data_i = data; tick();
    get_ack_i = 0; get_valid_i = 0;
    ok = ok1 & ok2;
  endtask

  task automatic test_reset();
    idle_inputs(); apply_reset();
    checks++; if ({put_req_o, get_req_o, busy_o, wd_err_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {put_req_o, get_req_o, busy_o, wd_err_o}); end
    checks++; if ({rx_valid_o, freeze_clk_o, ovr_o} !== 12'h000) begin
      errors++; $display("FAIL reset_vec: got %h want 000", {rx_valid_o, freeze_clk_o, ovr_o}); end
    checks++; if (rx_data_o !== '0) begin
      errors++; $display("FAIL reset_rx_data: got %h want 0", rx_data_o); end
    checks++; if ({put_ch_o, get_ch_o, put_data_o} !== 13'h0) begin
      errors++; $display("FAIL reset_put: got %h want 0", {put_ch_o, get_ch_o, put_data_o}); end
  endtask

  task automatic test_single();
    idle_inputs(); put_en_i = 1; get_en_i = 1; apply_reset();
    clk_h_i = 4'b0001; tick(); clk_h_i = '0;
    checks++; if ({busy_o, put_req_o} !== 2'b00) begin
      errors++; $display("FAIL single_lat_t1: got %b want 00", {busy_o, put_req_o}); end
    tick();
    checks++; if ({put_req_o, busy_o, put_ch_o} !== 4'b1100) begin
      errors++; $display("FAIL single_put_req: got %b want 1100", {put_req_o, busy_o, put_ch_o}); end
    checks++; if (put_data_o !== 9'h0F1) begin
      errors++; $display("FAIL single_put_data: got %h want 0f1", put_data_o); end
    put_ack_i = 1; tick(); put_ack_i = 0;
    checks++; if ({put_req_o, get_req_o, get_ch_o} !== 4'b0100) begin
      errors++; $display("FAIL single_get_req: got %b want 0100", {put_req_o, get_req_o, get_ch_o}); end
    get_ack_i = 1; get_valid_i = 1; get_data_i = 9'h1A5; tick();
    get_ack_i = 0; get_valid_i = 0;
    checks++; if ({rx_valid_o, busy_o, freeze_clk_o} !== 9'b0001_0_0000) begin
      errors++; $display("FAIL single_capture: got %b want 000100000", {rx_valid_o, busy_o, freeze_clk_o}); end
    checks++; if (rx_data_o[8:0] !== 9'h1A5) begin
      errors++; $display("FAIL single_rx_data: got %h want 1a5", rx_data_o[8:0]); end
    tick();
    checks++; if (rx_valid_o !== 4'b0000) begin
      errors++; $display("FAIL single_rx_pulse: got %b want 0000", rx_valid_o); end
  endtask

  task automatic test_round_robin();
    int got [4];
    int exp_ch [4];
    bit ok, all_ok;
    logic [8:0] dat [4];
    exp_ch = '{0, 1, 3, 0};
    dat = '{9'h011, 9'h022, 9'h033, 9'h044};
    idle_inputs(); put_en_i = 1; get_en_i = 1; apply_reset();
    clk_h_i = 4'b1011; tick(); clk_h_i = '0;
    all_ok = 1;
    for (int i = 0; i < 4; i++) begin
      serve((i == 1) ? 4'b0001 : 4'b0000, dat[i], got[i], ok);
      all_ok &= ok;
    end
    checks++; if (!all_ok) begin
      errors++; $display("FAIL rr_handshake: got timeout want completed"); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp_ch[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got[i], exp_ch[i]); end
    end
    checks++; if ({rx_data_o[27 +: 9], rx_data_o[9 +: 9], rx_data_o[0 +: 9]} !== {9'h033, 9'h022, 9'h044}) begin
      errors++; $display("FAIL rr_rx_data: got %h want %h", rx_data_o, {9'h033, 9'h000, 9'h022, 9'h044}); end
    checks++; if (ovr_o !== 4'b0000) begin
      errors++; $display("FAIL rr_ovr: got %b want 0000", ovr_o); end
  endtask

  task automatic test_freeze();
    bit ok;
    idle_inputs(); put_en_i = 1; get_en_i = 1; apply_reset();
    clk_h_i = 4'b0100; tick(); clk_h_i = '0;
    wait_put(ok); put_ack_i = 1; tick(); put_ack_i = 0;
    checks++; if (!ok || get_req_o !== 1'b1 || freeze_clk_o !== 4'b0000) begin
      errors++; $display("FAIL freeze_start: got req=%b frz=%b want req=1 frz=0000", get_req_o, freeze_clk_o); end
    for (int p = 0; p < 5; p++) begin
      get_ack_i = 1; get_valid_i = 0; tick();
      checks++; if ({get_req_o, freeze_clk_o} !== 5'b1_0100) begin
        errors++; $display("FAIL freeze_poll[%0d]: got %b want 10100", p, {get_req_o, freeze_clk_o}); end
    end
    get_ack_i = 1; get_valid_i = 1; get_data_i = 9'h055; tick();
    get_ack_i = 0; get_valid_i = 0;
    checks++; if ({freeze_clk_o, rx_valid_o} !== 8'b0000_0100) begin
      errors++; $display("FAIL freeze_release: got %b want 00000100", {freeze_clk_o, rx_valid_o}); end
    checks++; if (rx_data_o[18 +: 9] !== 9'h055) begin
      errors++; $display("FAIL freeze_rx_data: got %h want 055", rx_data_o[18 +: 9]); end
  endtask

  task automatic test_watchdog();
    bit ok;
    idle_inputs(); get_en_i = 1; apply_reset();
    clk_h_i = 4'b0010; tick(); clk_h_i = '0;
    wait_get(ok);
    checks++; if (!ok) begin
      errors++; $display("FAIL wd_enter_get: got timeout want get_req"); end
    for (int i = 1; i <= 15; i++) begin
      get_ack_i = (i % 3 == 0); tick();
      checks++; if ({get_req_o, wd_err_o} !== 2'b10) begin
        errors++; $display("FAIL wd_early[%0d]: got %b want 10", i, {get_req_o, wd_err_o}); end
    end
    get_ack_i = 0; tick();
    checks++; if ({wd_err_o, busy_o, put_req_o, get_req_o, freeze_clk_o} !== 8'b1100_1111) begin
      errors++; $display("FAIL wd_trip: got %b want 11001111", {wd_err_o, busy_o, put_req_o, get_req_o, freeze_clk_o}); end
    for (int i = 0; i < 4; i++) begin
      put_en_i = 1; put_ack_i = 1; get_ack_i = 1; get_valid_i = 1; clk_h_i = 4'(i); tick();
      checks++; if ({wd_err_o, busy_o, put_req_o, get_req_o, freeze_clk_o, rx_valid_o} !== 12'b1100_1111_0000) begin
        errors++; $display("FAIL wd_hold[%0d]: got %b want 110011110000", i,
                           {wd_err_o, busy_o, put_req_o, get_req_o, freeze_clk_o, rx_valid_o}); end
    end
    idle_inputs(); apply_reset();
    checks++; if ({wd_err_o, busy_o, freeze_clk_o} !== 6'b0) begin
      errors++; $display("FAIL wd_cleared: got %b want 000000", {wd_err_o, busy_o, freeze_clk_o}); end
  endtask

  task automatic test_overrun();
    bit ok;
    idle_inputs(); put_en_i = 1; get_en_i = 1; apply_reset();
    clk_h_i = 4'b0100; tick(); clk_h_i = '0;
    tick();
    clk_h_i = 4'b0100; tick(); clk_h_i = '0;
    checks++; if (ovr_o !== 4'b0100) begin
      errors++; $display("FAIL ovr_set: got %b want 0100", ovr_o); end
    put_ack_i = 1; tick(); put_ack_i = 0;
    get_ack_i = 1; get_valid_i = 1; get_data_i = 9'h0AB; tick(); get_ack_i = 0; get_valid_i = 0;
    tick(); tick(); tick();
    checks++; if ({ovr_o, busy_o} !== 5'b0100_0) begin
      errors++; $display("FAIL ovr_sticky_no_reservice: got %b want 01000", {ovr_o, busy_o}); end
    idle_inputs(); put_en_i = 1; get_en_i = 1; apply_reset();
    clk_h_i = 4'b0100; tick(); clk_h_i = '0;
    wait_put(ok); put_ack_i = 1; tick(); put_ack_i = 0;
    get_ack_i = 1; get_valid_i = 1; get_data_i = 9'h0AA; clk_h_i = 4'b0100; tick();
    get_ack_i = 0; get_valid_i = 0; clk_h_i = '0;
    checks++; if ({rx_valid_o, ovr_o} !== 8'b0100_0000) begin
      errors++; $display("FAIL ovr_same_cycle: got %b want 01000000", {rx_valid_o, ovr_o}); end
    wait_put(ok);
    checks++; if (!ok || put_ch_o !== 2'd2) begin
      errors++; $display("FAIL ovr_reservice: got ok=%0d ch=%0d want ok=1 ch=2", ok, put_ch_o); end
    put_ack_i = 1; tick(); put_ack_i = 0;
    get_ack_i = 1; get_valid_i = 1; tick(); get_ack_i = 0; get_valid_i = 0;
  endtask

  task automatic test_enables_reset();
    bit ok;
    logic seen;
    idle_inputs(); get_en_i = 1; apply_reset();
    clk_h_i = 4'b1000; tick(); clk_h_i = '0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin tick(); seen |= put_req_o; end
    checks++; if ({seen, get_req_o, get_ch_o} !== 4'b0111) begin
      errors++; $display("FAIL en_get_only: got %b want 0111", {seen, get_req_o, get_ch_o}); end
    get_ack_i = 1; get_valid_i = 1; get_data_i = 9'h1FF; tick(); get_ack_i = 0; get_valid_i = 0;
    checks++; if (rx_valid_o !== 4'b1000 || rx_data_o[27 +: 9] !== 9'h1FF) begin
      errors++; $display("FAIL en_get_capture: got %b/%h want 1000/1ff", rx_valid_o, rx_data_o[27 +: 9]); end
    get_en_i = 0;
    clk_h_i = 4'b0010; tick(); clk_h_i = '0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin tick(); seen |= busy_o | put_req_o | get_req_o; end
    put_en_i = 1; get_en_i = 1;
    for (int i = 0; i < 4; i++) begin tick(); seen |= busy_o | put_req_o | get_req_o; end
    checks++; if (seen !== 1'b0) begin
      errors++; $display("FAIL en_drop: got busy=%b want 0", seen); end
    clk_h_i = 4'b0001; tick(); clk_h_i = '0;
    wait_put(ok); put_ack_i = 1; tick(); put_ack_i = 0;
    checks++; if (!ok || get_req_o !== 1'b1) begin
      errors++; $display("FAIL rst_enter_get: got %b want 1", get_req_o); end
    rst_i = 1; get_ack_i = 1; get_valid_i = 1; get_data_i = 9'h123; tick();
    rst_i = 0; get_ack_i = 0; get_valid_i = 0;
    checks++; if ({rx_valid_o, busy_o, put_req_o, get_req_o, freeze_clk_o, ovr_o, wd_err_o} !== 16'h0) begin
      errors++; $display("FAIL rst_abort: got %b want 0", {rx_valid_o, busy_o, put_req_o, get_req_o, freeze_clk_o, ovr_o, wd_err_o}); end
    checks++; if (rx_data_o !== '0) begin
      errors++; $display("FAIL rst_rx_data: got %h want 0", rx_data_o); end
    tick();
    checks++; if ({rx_valid_o, busy_o} !== 5'b0) begin
      errors++; $display("FAIL rst_after: got %b want 00000", {rx_valid_o, busy_o}); end
  endtask

  initial begin
    tx_data_i = {9'h104, 9'h103, 9'h102, 9'h0F1};
    rst_i = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_freeze();
    test_watchdog();
    test_overrun();
    test_enables_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/part_2_xfer_sched.md
# part_2_xfer_sched

Transaction scheduler for one partition's fringe channel. It samples up to N_CH mission-clock strobes on the utility clock and turns each rising edge into a pending transfer. Pending transfers are granted round-robin onto a single shared put/get port toward the fringe interface. While a granted channel waits for data from the remote partition, the block freezes that channel's mission clock. A watchdog halts the partition if the remote side never answers.

## Interface
Parameters:
- N_CH, 4, number of mission-clock channels (2..8)
- DW, 9, joined payload width per channel ({wen, data[7:0]})
- CW, $clog2(N_CH), channel index width
- WD_LIMIT, 10000, GET poll cycles before watchdog error

Ports:
- clk_i  in  1  utility clock; only clock in the block
- rst_i  in  1  reset, synchronous, active-high
- clk_h_i  in  N_CH  mission clock levels, sampled on clk_i
- put_en_i  in  1  enable PUT phase
- get_en_i  in  1  enable GET phase
- tx_data_i  in  N_CH*DW  per-channel outbound payload; channel k occupies bits [k*DW +: DW]
- put_req_o  out  1  PUT request, level
- put_ch_o  out  CW  PUT channel index
- put_data_o  out  DW  PUT payload
- put_ack_i  in  1  PUT accepted, 1-cycle pulse
- get_req_o  out  1  GET poll request, level
- get_ch_o  out  CW  GET channel index
- get_ack_i  in  1  poll answered, 1-cycle pulse
- get_valid_i  in  1  qualifies get_ack_i: data present
- get_data_i  in  DW  received payload
- rx_valid_o  out  N_CH  one-cycle capture pulse per channel
- rx_data_o  out  N_CH*DW  last captured payload per channel; held between captures
- freeze_clk_o  out  N_CH  freeze request per mission clock
- ovr_o  out  N_CH  sticky overrun: edge arrived while channel already pending
- wd_err_o  out  1  sticky watchdog error
- busy_o  out  1  FSM not in IDLE

## Operation
Edge detection and pending:
- clk_h_d <= clk_h_i; rise = clk_h_i & ~clk_h_d.
- pending[k] is set on rise[k].
- pending[k] is cleared when channel k's transfer completes.
- If set and clear hit the same channel in the same cycle, set wins; no overrun is flagged.
- If rise[k] arrives while pending[k]=1 and no clear is happening, pending[k] stays 1 and ovr_o[k] is set.

Arbitration:
- Round-robin pointer last_gnt; the search starts at last_gnt+1 modulo N_CH.
- last_gnt resets to N_CH-1, so channel 0 wins first.
- The grant, the channel index and put_data_o are registered on leaving IDLE and held until return to IDLE.

FSM:
- IDLE: if any pending bit is set, grant a channel, then:
  - put_en_i=1 -> PUT
  - put_en_i=0, get_en_i=1 -> GET
  - both 0 -> clear the granted pending bit (drop) and stay in IDLE
- PUT: put_req_o=1. On put_ack_i -> GET if get_en_i, else complete -> IDLE.
- GET: get_req_o=1; watchdog counts cycles.
  - get_ack_i & get_valid_i: rx_data_o[g] <= get_data_i, pulse rx_valid_o[g], freeze_clk_o[g] <= 0, complete -> IDLE.
  - get_ack_i & ~get_valid_i: freeze_clk_o[g] <= 1, stay in GET.
  - Watchdog reaching WD_LIMIT with no valid data -> ERR.
- ERR: all requests low, freeze_clk_o all 1, wd_err_o=1, busy_o=1. Exit only by rst_i.

Other rules:
- Complete means: clear pending[g], last_gnt <= g, watchdog <= 0.
- Watchdog is a 32-bit counter, cleared on entering GET. It does not wrap.
- put_en_i and get_en_i are sampled only at IDLE exit and at PUT completion. Changes mid-phase are ignored.

## Timing
Reset values (rst_i=1 at a clk_i edge):
- FSM = IDLE, pending = 0, clk_h_d = 0.
- All outputs 0.
- last_gnt = N_CH-1.
- Reset mid-transfer aborts with no completion and no rx_valid_o pulse.

Latency and handshake:
- clk_h_i rise sampled at edge T -> pending set at T+1 -> put_req_o high at T+2 (when IDLE and granted).
- put_ack_i seen at edge A -> put_req_o low and get_req_o high from A+1.
- get_ack_i & get_valid_i at edge C -> rx_valid_o[g] high exactly at C+1, busy_o low at C+1. The next grant can occur at C+1 (its request rises at C+2).
- freeze_clk_o[g] rises the cycle after the first empty poll and falls the cycle after capture.
- Acks received outside the matching state are ignored.
- Minimum transfer with immediate acks is 4 cycles, IDLE to IDLE.

## Test plan
- Single transfer: reset, put_en_i=get_en_i=1, rise on clk_h_i[0], immediate put_ack_i, get answered valid with data 9'h1A5 on first poll -> put_ch_o=0, put_data_o=tx_data_i[0], rx_valid_o=4'b0001 pulse, rx_data_o[0]=9'h1A5, freeze_clk_o stays 0.
- Round-robin: rises on channels 0, 1 and 3 in the same cycle -> grant order 0, 1, 3; a repeat rise on channel 0 during channel 1's transfer -> order 0, 1, 3, 0.
- Freeze: get_ack_i with get_valid_i=0 for 5 polls, then valid -> freeze_clk_o[g] high for exactly those poll cycles plus one, then low.
- Watchdog: WD_LIMIT=16, get_valid_i never asserted -> after 16 GET cycles wd_err_o=1, freeze_clk_o=all 1, requests low; held until rst_i.
- Overrun and same-cycle set/clear: second rise[2] while pending[2] -> ovr_o[2]=1; rise[2] in the completion cycle of channel 2 -> ovr_o[2] unchanged and channel 2 is re-serviced.
- Enables and reset: put_en_i=0, get_en_i=1 -> GET only, no put_req_o. Both 0 -> pending dropped, busy_o stays 0. rst_i during GET -> all outputs 0 next cycle, no rx_valid_o.
